// File: rtl/dm_store_buffer_pkg.sv
// Shared widths, entry layout and lane-merge helper for the data-memory store buffer.
package dm_store_buffer_pkg;

    localparam int unsigned SB_DEPTH = 4;
    localparam int unsigned WORD_W   = 30;
    localparam int unsigned BE_W     = 4;
    localparam int unsigned DATA_W   = 32;

    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

    // Overwrite only the byte lanes enabled in be; other lanes keep old_data.
    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_data,
        input logic [DATA_W-1:0] new_data,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_data;
        for (int unsigned i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_data[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dm_store_buffer_sb_match.sv
// Per-entry word-address compare: load overlap (address and byte lanes) and store merge hit.
module sb_match
    import dm_store_buffer_pkg::*;
(
    input  logic              ent_valid_i,
    input  logic [WORD_W-1:0] ent_word_i,
    input  logic [BE_W-1:0]   ent_be_i,
    input  logic [WORD_W-1:0] ld_word_i,
    input  logic [BE_W-1:0]   ld_be_i,
    input  logic [WORD_W-1:0] st_word_i,
    output logic              ld_hit_o,
    output logic              st_hit_o
);

    assign ld_hit_o = ent_valid_i && (ent_word_i == ld_word_i) && (|(ent_be_i & ld_be_i));
    assign st_hit_o = ent_valid_i && (ent_word_i == st_word_i);

endmodule

// File: rtl/dm_store_buffer.sv
// Posted-write FIFO between the MEM-stage store path and the single-port data memory,
// with store merging into the youngest entry and load-overlap stall detection.
module dm_store_buffer
    import dm_store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned PTR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    input  logic [31:0]       st_addr,
    input  logic [BE_W-1:0]   st_be,
    input  logic [DATA_W-1:0] st_wdata,
    output logic              st_ready,
    input  logic              ld_req,
    input  logic [31:0]       ld_addr,
    input  logic [BE_W-1:0]   ld_be,
    output logic              ld_stall,
    input  logic              dm_busy,
    output logic              dm_we,
    output logic [31:0]       dm_addr,
    output logic [BE_W-1:0]   dm_be,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              empty
);

    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    sb_entry_t        ent_q [DEPTH];
    sb_entry_t        ent_d [DEPTH];

    logic [WORD_W-1:0] st_word;
    logic [WORD_W-1:0] ld_word;
    logic [DEPTH-1:0]  ld_hit;
    logic [DEPTH-1:0]  st_hit;
    logic [PTR_W-1:0]  youngest;
    logic              accept;
    logic              drain;
    logic              merge;
    logic              alloc;
    logic              unused_addr_lsbs;

    assign st_word          = st_addr[31:2];
    assign ld_word          = ld_addr[31:2];
    assign unused_addr_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        sb_match u_match (
            .ent_valid_i (valid_q[g]),
            .ent_word_i  (ent_q[g].word),
            .ent_be_i    (ent_q[g].be),
            .ld_word_i   (ld_word),
            .ld_be_i     (ld_be),
            .st_word_i   (st_word),
            .ld_hit_o    (ld_hit[g]),
            .st_hit_o    (st_hit[g])
        );
    end

    assign st_ready = (count_q < CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign drain    = (count_q != '0) && !dm_busy;
    assign accept   = st_valid && st_ready;
    assign youngest = PTR_W'(tail_q - PTR_W'(1));
    // The youngest entry is the one leaving only when it is also the sole entry.
    assign merge    = accept && (count_q != '0) && st_hit[youngest]
                      && !(drain && (count_q == CNT_W'(1)));
    assign alloc    = accept && !merge;

    assign ld_stall = ld_req && (|ld_hit);
    assign dm_we    = drain;
    assign dm_addr  = drain ? {ent_q[head_q].word, 2'b00} : '0;
    assign dm_be    = drain ? ent_q[head_q].be : '0;
    assign dm_wdata = drain ? ent_q[head_q].data : '0;

    // Next-state for pointers, count and entry storage.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        ent_d   = ent_q;
        count_d = count_q + CNT_W'(alloc) - CNT_W'(drain);

        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = PTR_W'(head_q + PTR_W'(1));
        end

        if (merge) begin
            ent_d[youngest].be   = ent_q[youngest].be | st_be;
            ent_d[youngest].data = merge_lanes(ent_q[youngest].data, st_wdata, st_be);
        end else if (alloc) begin
            ent_d[tail_q]   = '{word: st_word, be: st_be, data: st_wdata};
            valid_d[tail_q] = 1'b1;
            tail_d          = PTR_W'(tail_q + PTR_W'(1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            ent_q   <= ent_d;
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed bench for dm_store_buffer: expected memory writes are queued at stimulus time
// and checked in order by a monitor as the buffer drains.
module tb_dm_store_buffer;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic        st_ready;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [3:0]  ld_be;
    logic        ld_stall;
    logic        dm_busy;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        empty;

    int   checks = 0;
    int   errors = 0;
    wr_t  exp_q[$];

    dm_store_buffer dut (
        .clk      (clk),
        .reset    (reset),
        .st_valid (st_valid),
        .st_addr  (st_addr),
        .st_be    (st_be),
        .st_wdata (st_wdata),
        .st_ready (st_ready),
        .ld_req   (ld_req),
        .ld_addr  (ld_addr),
        .ld_be    (ld_be),
        .ld_stall (ld_stall),
        .dm_busy  (dm_busy),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_be    (dm_be),
        .dm_wdata (dm_wdata),
        .empty    (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_st(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_be    = be;
        st_wdata = d;
    endtask

    task automatic idle_st();
        st_valid = 1'b0;
        st_addr  = '0;
        st_be    = '0;
        st_wdata = '0;
    endtask

    function automatic wr_t mk(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        wr_t w;
        w.addr = {a[31:2], 2'b00};
        w.be   = be;
        w.data = d;
        return w;
    endfunction

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 20 && !empty; i++) step();
        chk(tag, 32'(empty), 32'd1);
    endtask

    // Scoreboard monitor: every memory write must match the oldest expected write.
    always @(negedge clk) begin
        if (reset && dm_we) begin
            chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", dm_addr, e.addr);
                chk("wr_be", 32'(dm_be), 32'(e.be));
                chk("wr_data", dm_wdata & lane_mask(e.be), e.data & lane_mask(e.be));
            end
        end
    end

    initial begin
        reset   = 1'b0;
        ld_req  = 1'b0;
        ld_addr = '0;
        ld_be   = '0;
        dm_busy = 1'b0;
        idle_st();
        #2;
        chk("rst_st_ready", 32'(st_ready), 32'd1);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_dm_we", 32'(dm_we), 32'd0);
        chk("rst_ld_stall", 32'(ld_stall), 32'd0);
        chk("rst_dm_addr", dm_addr, 32'd0);
        chk("rst_dm_be", 32'(dm_be), 32'd0);
        chk("rst_dm_wdata", dm_wdata, 32'd0);
        step();
        reset = 1'b1;

        // Single store writes memory in the very next cycle.
        step();
        drive_st(32'h0000_1004, 4'hF, 32'hDEAD_BEEF);
        exp_q.push_back(mk(32'h0000_1004, 4'hF, 32'hDEAD_BEEF));
        step();
        idle_st();
        #1;
        chk("single_we", 32'(dm_we), 32'd1);
        chk("single_addr", dm_addr, 32'h0000_1004);
        chk("single_be", 32'(dm_be), 32'hF);
        chk("single_data", dm_wdata, 32'hDEAD_BEEF);
        step();
        chk("single_empty", 32'(empty), 32'd1);

        // Two byte stores to one word merge into a single entry.
        dm_busy = 1'b1;
        drive_st(32'h0000_1000, 4'b0001, 32'h0000_00AA);
        step();
        drive_st(32'h0000_1001, 4'b0010, 32'h0000_BB00);
        step();
        idle_st();
        chk("merge_pending", 32'(empty), 32'd0);
        exp_q.push_back(mk(32'h0000_1000, 4'b0011, 32'h0000_BBAA));
        dm_busy = 1'b0;
        #1;
        chk("merge_be", 32'(dm_be), 32'h3);
        chk("merge_data", 32'(dm_wdata[15:0]), 32'hBBAA);
        step();
        chk("merge_empty", 32'(empty), 32'd1);

        // Fill to DEPTH while memory is busy; fifth store is refused.
        dm_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_st(32'h100 * (i + 1), 4'hF, 32'hA000_0000 + 32'(i));
            #1;
            chk("fill_ready", 32'(st_ready), 32'(i < 4));
            if (i < 4) exp_q.push_back(mk(32'h100 * (i + 1), 4'hF, 32'hA000_0000 + 32'(i)));
            step();
        end
        idle_st();
        chk("full_ready", 32'(st_ready), 32'd0);
        dm_busy = 1'b0;
        wait_empty("fill_drain");

        // Second burst after pointer wrap, then drain coincides with a refused store.
        dm_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_st(32'h5000 + 32'(16 * i), 4'hF, 32'hB000_0000 + 32'(i));
            exp_q.push_back(mk(32'h5000 + 32'(16 * i), 4'hF, 32'hB000_0000 + 32'(i)));
            step();
        end
        idle_st();
        chk("wrap_full", 32'(st_ready), 32'd0);
        drive_st(32'h6000, 4'hF, 32'h6666_6666);
        dm_busy = 1'b0;
        #1;
        chk("full_drain_ready", 32'(st_ready), 32'd0);
        chk("full_drain_we", 32'(dm_we), 32'd1);
        step();
        idle_st();
        chk("after_drain_ready", 32'(st_ready), 32'd1);
        wait_empty("wrap_drain");

        // Accept and drain in one cycle keep the count unchanged.
        dm_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_st(32'h7000 + 32'(4 * i), 4'hF, 32'hC000_0000 + 32'(i));
            exp_q.push_back(mk(32'h7000 + 32'(4 * i), 4'hF, 32'hC000_0000 + 32'(i)));
            step();
        end
        drive_st(32'h7100, 4'hF, 32'hC100_0000);
        exp_q.push_back(mk(32'h7100, 4'hF, 32'hC100_0000));
        dm_busy = 1'b0;
        step();
        idle_st();
        dm_busy = 1'b1;
        chk("acc_drain_ready", 32'(st_ready), 32'd1);
        drive_st(32'h7200, 4'hF, 32'hC200_0000);
        exp_q.push_back(mk(32'h7200, 4'hF, 32'hC200_0000));
        step();
        idle_st();
        chk("acc_drain_full", 32'(st_ready), 32'd0);
        dm_busy = 1'b0;
        wait_empty("acc_drain_empty");

        // Streaming: one accepted and one drained per cycle.
        for (int i = 0; i < 6; i++) begin
            drive_st(32'h8000 + 32'(4 * i), 4'hF, 32'hD000_0000 + 32'(i));
            exp_q.push_back(mk(32'h8000 + 32'(4 * i), 4'hF, 32'hD000_0000 + 32'(i)));
            #1;
            chk("stream_ready", 32'(st_ready), 32'd1);
            chk("stream_we", 32'(dm_we), 32'(i > 0));
            step();
        end
        idle_st();
        step();
        chk("stream_empty", 32'(empty), 32'd1);

        // Same word as a sole entry that is draining must allocate, not merge.
        dm_busy = 1'b1;
        drive_st(32'h3000, 4'b0001, 32'h0000_0011);
        exp_q.push_back(mk(32'h3000, 4'b0001, 32'h0000_0011));
        step();
        dm_busy = 1'b0;
        drive_st(32'h3000, 4'b0010, 32'h0000_2200);
        exp_q.push_back(mk(32'h3000, 4'b0010, 32'h0000_2200));
        step();
        idle_st();
        wait_empty("nomerge_drain");

        // Load-overlap stall on a pending halfword store.
        dm_busy = 1'b1;
        drive_st(32'h2002, 4'b1100, 32'h5678_0000);
        exp_q.push_back(mk(32'h2002, 4'b1100, 32'h5678_0000));
        step();
        idle_st();
        ld_req  = 1'b1;
        ld_addr = 32'h2000;
        ld_be   = 4'b0011;
        #1;
        chk("ld_lo_lanes", 32'(ld_stall), 32'd0);
        ld_be = 4'b1111;
        #1;
        chk("ld_overlap", 32'(ld_stall), 32'd1);
        ld_addr = 32'h2004;
        #1;
        chk("ld_other_word", 32'(ld_stall), 32'd0);
        ld_addr = 32'h2000;
        ld_req  = 1'b0;
        #1;
        chk("ld_no_req", 32'(ld_stall), 32'd0);
        ld_req = 1'b1;
        step();
        chk("ld_hold", 32'(ld_stall), 32'd1);
        dm_busy = 1'b0;
        #1;
        chk("ld_during_drain", 32'(ld_stall), 32'd1);
        step();
        chk("ld_release", 32'(ld_stall), 32'd0);
        drive_st(32'h2400, 4'hF, 32'h2400_2400);
        exp_q.push_back(mk(32'h2400, 4'hF, 32'h2400_2400));
        ld_addr = 32'h2400;
        #1;
        chk("ld_same_cycle_store", 32'(ld_stall), 32'd0);
        step();
        idle_st();
        ld_req = 1'b0;
        wait_empty("ld_drain");

        // Reset mid-drain drops pending stores.
        dm_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_st(32'h9000 + 32'(4 * i), 4'hF, 32'hE000_0000 + 32'(i));
            step();
        end
        idle_st();
        chk("pre_rst_pending", 32'(empty), 32'd0);
        dm_busy = 1'b0;
        reset   = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_we", 32'(dm_we), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_ready", 32'(st_ready), 32'd1);
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_we", 32'(dm_we), 32'd0);
        end
        chk("post_rst_empty", 32'(empty), 32'd1);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
